// File: rtl/tcdm_bank_arb.sv
// Round-robin arbiter for one TCDM bank port, with a fixed-latency response
// pipeline that routes each bank response back to the requester that was granted.
module tcdm_bank_arb #(
    parameter int unsigned NumIn         = 8,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned MemLatency    = 1,
    parameter bit          WriteRespOn   = 1'b1,
    parameter bit          ExtPrio       = 1'b0,
    localparam int unsigned IdxW         = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumIn-1:0]                    req_i,
    input  logic [NumIn-1:0]                    wen_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]  wdata_i,
    output logic [NumIn-1:0]                    gnt_o,
    output logic [NumIn-1:0]                    vld_o,
    output logic [NumIn-1:0][RespDataWidth-1:0] rdata_o,
    input  logic [IdxW-1:0]                     rr_i,
    output logic                                req_o,
    output logic                                wen_o,
    output logic [ReqDataWidth-1:0]             wdata_o,
    input  logic                                gnt_i,
    input  logic [RespDataWidth-1:0]            rdata_i
);

    if (MemLatency < 1) begin : g_bad_latency
        $fatal(1, "tcdm_bank_arb: MemLatency must be >= 1");
    end

    logic [IdxW-1:0] rr_q, ptr, ptr_mod, winner;
    logic [31:0]     cand;
    logic            hs, resp_v;
    logic [MemLatency-1:0]           vld_pipe;
    logic [MemLatency-1:0][IdxW-1:0] idx_pipe;

    // Pointer range is below 2*NumIn, so one conditional subtract is a full modulo.
    assign ptr     = ExtPrio ? rr_i : rr_q;
    assign ptr_mod = (32'(ptr) >= NumIn) ? ptr - IdxW'(NumIn) : ptr;

    // Scan from farthest to nearest offset so the closest requester wins last.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int off = int'(NumIn) - 1; off >= 0; off--) begin
            cand = 32'(ptr_mod) + 32'(off);
            if (cand >= NumIn) cand = cand - NumIn;
            if (req_i[cand[IdxW-1:0]]) winner = cand[IdxW-1:0];
        end
    end

    assign req_o   = |req_i;
    assign wen_o   = req_o & wen_i[winner];
    assign wdata_o = req_o ? wdata_i[winner] : '0;
    assign hs      = req_o & gnt_i;
    assign resp_v  = hs & (~wen_o | WriteRespOn);

    always_comb begin
        gnt_o = '0;
        vld_o = '0;
        for (int i = 0; i < int'(NumIn); i++) begin
            gnt_o[i]   = hs && (winner == IdxW'(i));
            vld_o[i]   = vld_pipe[MemLatency-1] && (idx_pipe[MemLatency-1] == IdxW'(i));
            rdata_o[i] = rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            vld_pipe <= '0;
            idx_pipe <= '0;
        end else begin
            if (!ExtPrio && hs)
                rr_q <= (32'(winner) == NumIn - 1) ? '0 : winner + 1'b1;
            vld_pipe[0] <= resp_v;
            idx_pipe[0] <= winner;
            for (int k = 1; k < int'(MemLatency); k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                idx_pipe[k] <= idx_pipe[k-1];
            end
        end
    end

    a_gnt_onehot: assert property (@(posedge clk_i) $onehot0(gnt_o));
    a_vld_onehot: assert property (@(posedge clk_i) $onehot0(vld_o));

endmodule

// File: tb/tb_tcdm_bank_arb.sv
// Bench for tcdm_bank_arb: two configurations driven with directed and random
// traffic, checked every cycle against a queue-based behavioural model.
module tb_tcdm_bank_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NumIn=4, MemLatency=3, write responses, internal round-robin.
    logic [3:0]       a_req, a_wen, a_gnt_o, a_vld_o;
    logic [3:0][31:0] a_wdata, a_rdata_o;
    logic [1:0]       a_rr;
    logic             a_req_o, a_wen_o, a_gnt_i;
    logic [31:0]      a_wdata_o, a_rdata_i;

    // Instance B: NumIn=3, MemLatency=2, no write responses, external priority.
    logic [2:0]       b_req, b_wen, b_gnt_o, b_vld_o;
    logic [2:0][31:0] b_wdata, b_rdata_o;
    logic [1:0]       b_rr;
    logic             b_req_o, b_wen_o, b_gnt_i;
    logic [31:0]      b_wdata_o, b_rdata_i;

    tcdm_bank_arb #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32), .MemLatency(3),
                    .WriteRespOn(1'b1), .ExtPrio(1'b0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .wen_i(a_wen), .wdata_i(a_wdata),
        .gnt_o(a_gnt_o), .vld_o(a_vld_o), .rdata_o(a_rdata_o), .rr_i(a_rr),
        .req_o(a_req_o), .wen_o(a_wen_o), .wdata_o(a_wdata_o), .gnt_i(a_gnt_i),
        .rdata_i(a_rdata_i));

    tcdm_bank_arb #(.NumIn(3), .ReqDataWidth(32), .RespDataWidth(32), .MemLatency(2),
                    .WriteRespOn(1'b0), .ExtPrio(1'b1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .wen_i(b_wen), .wdata_i(b_wdata),
        .gnt_o(b_gnt_o), .vld_o(b_vld_o), .rdata_o(b_rdata_o), .rr_i(b_rr),
        .req_o(b_req_o), .wen_o(b_wen_o), .wdata_o(b_wdata_o), .gnt_i(b_gnt_i),
        .rdata_i(b_rdata_i));

    int checks = 0;
    int errors = 0;
    longint cyc = 0;

    int nn[2]  = '{4, 3};
    int ml[2]  = '{3, 2};
    int wr[2]  = '{1, 0};
    int ext[2] = '{0, 1};
    int rr_m[2] = '{0, 0};

    typedef struct {
        int     inst;
        longint due;
        int     idx;
    } resp_t;
    resp_t pend[$];

    task automatic cmp(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0h want %0h at t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // Model: priority scan, then a list of responses each due at a fixed cycle.
    task automatic chk(input int d, input logic rst, input logic [3:0] req, input logic [3:0] wen,
                       input logic [3:0][31:0] wd, input int pext, input logic gi,
                       input logic [3:0] gnt, input logic [3:0] vld, input logic rq, input logic we,
                       input logic [31:0] wdo, input logic [31:0] rdi, input logic [3:0][31:0] rdo);
        int n = nn[d];
        int p;
        int win = -1;
        logic [3:0] eg = '0;
        logic [3:0] ev = '0;
        logic [31:0] ewd = '0;
        logic ewe = 1'b0;
        logic [3:0][31:0] erd = '0;
        if (!rst) begin
            rr_m[d] = 0;
            for (int i = pend.size() - 1; i >= 0; i--)
                if (pend[i].inst == d) pend.delete(i);
        end
        p = (ext[d] != 0) ? (pext % n) : rr_m[d];
        for (int off = 0; off < n; off++)
            if (win < 0 && req[(p + off) % n]) win = (p + off) % n;
        if (win >= 0) begin
            ewe = wen[win];
            ewd = wd[win];
            if (gi) eg[win] = 1'b1;
        end
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].inst == d && pend[i].due == cyc) begin
                ev[pend[i].idx] = 1'b1;
                pend.delete(i);
            end
        for (int k = 0; k < n; k++) erd[k] = rdi;
        cmp("req_o",   d, 128'(rq),  128'(|req));
        cmp("gnt_o",   d, 128'(gnt), 128'(eg));
        cmp("wen_o",   d, 128'(we),  128'(ewe));
        cmp("wdata_o", d, 128'(wdo), 128'(ewd));
        cmp("vld_o",   d, 128'(vld), 128'(ev));
        cmp("rdata_o", d, rdo,       erd);
        if (rst && win >= 0 && gi) begin
            if (ext[d] == 0) rr_m[d] = (win + 1) % n;
            if (!wen[win] || wr[d] != 0)
                pend.push_back('{inst: d, due: cyc + longint'(ml[d]), idx: win});
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        chk(0, rst_n, a_req, a_wen, a_wdata, int'(a_rr), a_gnt_i, a_gnt_o, a_vld_o,
            a_req_o, a_wen_o, a_wdata_o, a_rdata_i, a_rdata_o);
        chk(1, rst_n, {1'b0, b_req}, {1'b0, b_wen}, {32'h0, b_wdata}, int'(b_rr), b_gnt_i,
            {1'b0, b_gnt_o}, {1'b0, b_vld_o}, b_req_o, b_wen_o, b_wdata_o, b_rdata_i,
            {32'h0, b_rdata_o});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input logic [3:0] r, input logic [3:0] w, input logic g);
        a_req = r; a_wen = w; a_gnt_i = g;
        for (int k = 0; k < 4; k++) a_wdata[k] = $urandom;
    endtask

    task automatic b_set(input logic [2:0] r, input logic [2:0] w, input logic g, input logic [1:0] rr);
        b_req = r; b_wen = w; b_gnt_i = g; b_rr = rr;
        for (int k = 0; k < 3; k++) b_wdata[k] = $urandom;
    endtask

    initial begin
        logic [3:0] one;
        one = 4'b0001;
        a_set(4'b0000, 4'b0000, 1'b0); a_rr = 2'd0; a_rdata_i = '0;
        b_set(3'b000, 3'b000, 1'b0, 2'd0); b_rdata_i = '0;
        rst_n = 1'b0;
        @(negedge clk);
        cmp("rst_vld", 0, 128'(a_vld_o), 128'(4'b0000));
        cmp("rst_vld", 1, 128'(b_vld_o), 128'(3'b000));
        tick();
        rst_n = 1'b1;

        // Fairness: all requesting, bank always granting.
        for (int i = 0; i < 8; i++) begin
            a_set(4'b1111, 4'b0000, 1'b1);
            @(negedge clk);
            cmp("fair_gnt", 0, 128'(a_gnt_o), 128'(one << (i % 4)));
            tick();
        end

        // Bank stall keeps the pointer where it was.
        for (int i = 0; i < 3; i++) begin
            a_set(4'b0110, 4'b0000, 1'b0);
            @(negedge clk);
            cmp("stall_gnt", 0, 128'(a_gnt_o), 128'(4'b0000));
            tick();
        end
        a_set(4'b0110, 4'b0000, 1'b1);
        @(negedge clk); cmp("stall_grant", 0, 128'(a_gnt_o), 128'(4'b0010));
        tick();
        @(negedge clk); cmp("stall_next", 0, 128'(a_gnt_o), 128'(4'b0100));
        tick();

        // Response routing: loads from 2 then 0, seen 3 cycles later each.
        a_set(4'b0100, 4'b0000, 1'b1);
        @(negedge clk); cmp("route_gnt2", 0, 128'(a_gnt_o), 128'(4'b0100));
        tick();
        a_set(4'b0001, 4'b0000, 1'b1);
        @(negedge clk); cmp("route_gnt0", 0, 128'(a_gnt_o), 128'(4'b0001));
        tick();
        a_set(4'b0000, 4'b0000, 1'b0);
        tick();
        a_rdata_i = 32'hCAFE_0002;
        @(negedge clk);
        cmp("route_vld2", 0, 128'(a_vld_o), 128'(4'b0100));
        cmp("route_rdata2", 0, 128'(a_rdata_o[2]), 128'(32'hCAFE_0002));
        tick();
        @(negedge clk); cmp("route_vld0", 0, 128'(a_vld_o), 128'(4'b0001));
        tick();

        // Store from requester 1 answers when write responses are on.
        a_set(4'b0010, 4'b0010, 1'b1);
        @(negedge clk); cmp("wr_gnt", 0, 128'(a_gnt_o), 128'(4'b0010));
        tick();
        a_set(4'b0000, 4'b0000, 1'b0);
        tick();
        tick();
        @(negedge clk); cmp("wr_vld", 0, 128'(a_vld_o), 128'(4'b0010));
        tick();

        // External priority, including an out-of-range pointer (3 mod 3 = 0).
        b_set(3'b101, 3'b000, 1'b1, 2'd2);
        @(negedge clk); cmp("ext_rr2", 1, 128'(b_gnt_o), 128'(3'b100));
        tick();
        b_set(3'b101, 3'b000, 1'b1, 2'd0);
        @(negedge clk); cmp("ext_rr0", 1, 128'(b_gnt_o), 128'(3'b001));
        tick();
        b_set(3'b110, 3'b000, 1'b1, 2'd3);
        @(negedge clk); cmp("ext_rr3", 1, 128'(b_gnt_o), 128'(3'b010));
        tick();

        // Store without write responses produces no valid.
        b_set(3'b010, 3'b010, 1'b1, 2'd0);
        @(negedge clk); cmp("nowr_gnt", 1, 128'(b_gnt_o), 128'(3'b010));
        tick();
        b_set(3'b000, 3'b000, 1'b0, 2'd0);
        tick();
        @(negedge clk); cmp("nowr_vld", 1, 128'(b_vld_o), 128'(3'b000));
        tick();

        // Reset while a load is in flight drops it and rewinds the pointer.
        b_set(3'b001, 3'b000, 1'b1, 2'd0);
        @(negedge clk); cmp("rst_hs_gnt", 1, 128'(b_gnt_o), 128'(3'b001));
        tick();
        rst_n = 1'b0;
        b_set(3'b000, 3'b000, 1'b0, 2'd0);
        a_set(4'b0000, 4'b0000, 1'b0);
        tick();
        rst_n = 1'b1;
        a_set(4'b1111, 4'b0000, 1'b1);
        @(negedge clk);
        cmp("rst_drop_vld", 1, 128'(b_vld_o), 128'(3'b000));
        cmp("rst_rr_a", 0, 128'(a_gnt_o), 128'(4'b0001));
        tick();

        // Random traffic with occasional resets.
        repeat (3000) begin
            rst_n = ($urandom_range(0, 199) != 0);
            a_set(4'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
            a_rr = 2'($urandom);
            a_rdata_i = $urandom;
            b_set(3'($urandom), 3'($urandom), $urandom_range(0, 3) != 0, 2'($urandom));
            b_rdata_i = $urandom;
            tick();
        end
        rst_n = 1'b1;
        a_set(4'b0000, 4'b0000, 1'b0);
        b_set(3'b000, 3'b000, 1'b0, 2'd0);
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcdm_bank_arb.md
Name: tcdm_bank_arb

Overview:
Per-bank arbiter and response router for the TCDM interconnect. Shares one memory bank port between NumIn requesters using round-robin priority, and tracks granted transactions through a MemLatency-deep pipeline. Each read response, and optionally each write response, returns to the requester that was granted. Sits between the last interconnect stage and a single SRAM bank; one instance per bank.

Parameters:
NumIn, 8, number of requesters; any value >=1; pointer width IdxW = max(1, $clog2(NumIn)).
ReqDataWidth, 32, request payload width (address LSBs + wdata + be, opaque to this block).
RespDataWidth, 32, response data width.
MemLatency, 1, cycles from bank handshake to rdata_i valid; must be >=1.
WriteRespOn, 1, 1: writes also produce vld_o; 0: only reads do.
ExtPrio, 0, 1: priority pointer taken from rr_i; 0: internal round-robin pointer.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NumIn  request per requester
wen_i  in  NumIn  1 store, 0 load
wdata_i  in  NumIn x ReqDataWidth  request payload
gnt_o  out  NumIn  grant, at most one bit set
vld_o  out  NumIn  response valid, at most one bit set
rdata_o  out  NumIn x RespDataWidth  response data, broadcast copy of rdata_i
rr_i  in  IdxW  external priority pointer, used only when ExtPrio=1
req_o  out  1  bank request
wen_o  out  1  winner's wen
wdata_o  out  ReqDataWidth  winner's payload
gnt_i  in  1  bank grant
rdata_i  in  RespDataWidth  bank read data, valid MemLatency cycles after handshake

Behaviour:
- Reset: rst_ni asynchronous, active-low; clock clk_i. Reset clears rr_q to 0 and clears all pipeline valid bits.
- Outputs during reset: vld_o=0. gnt_o/req_o remain combinational functions of the inputs.
- Priority pointer: p = ExtPrio ? rr_i : rr_q. Values >=NumIn are reduced modulo NumIn.
- Winner (combinational): the first index i with req_i[i]=1, scanning p, p+1, ..., NumIn-1, 0, ..., p-1.
- Bank request: req_o = |req_i. wen_o/wdata_o carry the winner's wen/wdata. When req_o=0, wen_o=0 and wdata_o=0.
- Grant: gnt_o[winner] = req_o & gnt_i; all other bits are 0. Zero-cycle combinational path from gnt_i.
- Handshake: hs = req_o & gnt_i.
- Pointer update (ExtPrio=0 only): on hs, rr_q <= winner+1, wrapping NumIn-1 -> 0; otherwise rr_q holds. With ExtPrio=1, rr_q is not updated.
- Response pipeline: MemLatency stages, each holding {v, idx}.
  - Stage 0 loads v = hs & (~wen_o | WriteRespOn) and idx = winner on every cycle.
  - Stage k loads from stage k-1 every cycle; no stall.
- Response output: vld_o[idx_last] = v_last, where last is stage MemLatency-1. A response appears exactly MemLatency cycles after its handshake.
- Back-to-back traffic: one handshake per cycle is sustained. Up to MemLatency responses are in flight.
- rdata_o[k] = rdata_i for all k. Only vld_o qualifies the data.
- Simultaneous events: a new handshake and a retiring response in the same cycle are independent and both occur.
- Reset mid-operation: in-flight responses are dropped; no vld_o follows reset release.
- NumIn=1: pointer logic degenerates; the winner is always 0.
- Simulation-only assertions:
  - MemLatency >= 1 (fatal).
  - $onehot0(gnt_o) and $onehot0(vld_o) every cycle.
  - gnt_i=1 while req_o=0 is legal and ignored.

Test Plan:
- Fairness, NumIn=4, ExtPrio=0, all req_i=4'b1111, gnt_i=1 for 8 cycles -> gnt_o sequence 0001, 0010, 0100, 1000, 0001, ...; rr_q wraps from 3 to 0.
- Bank stall: req_i=4'b0110, gnt_i=0 for 3 cycles then 1 -> gnt_o=0 and rr_q=0 while stalled. On the grant cycle gnt_o=0010 and rr_q becomes 2; next grant goes to requester 2.
- Response routing, MemLatency=3: loads from requester 2 at cycle 10 and requester 0 at cycle 11 -> vld_o=0100 at cycle 13 and 0001 at cycle 14. rdata_o[2] equals the rdata_i presented at cycle 13.
- Write responses: a store from requester 1 -> vld_o=0010 after MemLatency cycles with WriteRespOn=1; vld_o stays 0 with WriteRespOn=0.
- External priority, ExtPrio=1: rr_i=3, req_i=4'b1001 -> gnt_o=1000. With rr_i=0 -> gnt_o=0001. rr_q stays 0.
- Reset mid-flight, MemLatency=2: handshake at cycle 5, rst_ni low during cycle 6 -> no vld_o at cycle 7; rr_q=0 after reset.
